// File: rtl/i2c_pkg.sv
// Definitions shared between the sensor poller and the I2C master:
// poller states, WR encodings and the default sensor target.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } poll_state_e;

  localparam logic I2C_WRITE = 1'b1;
  localparam logic I2C_READ  = 1'b0;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'b1001100;
  localparam logic [7:0] DEFAULT_SUB_ADDR = 8'h01;

  // Received-byte counter stops at 3 so an over-read is still distinguishable.
  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? 2'd3 : v + 2'd1;
  endfunction

endpackage

// File: rtl/i2c_sensor_poller_timer.sv
// Free-running poll interval counter; emits a one-cycle tick each time it wraps.
module poll_timer
  import i2c_pkg::*;
#(
  parameter int unsigned POLL_DIV = 5000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  output logic tick_o
);

  localparam int unsigned   CW   = (POLL_DIV > 32'd1) ? $clog2(POLL_DIV) : 32'd1;
  localparam logic [CW-1:0] LAST = CW'(POLL_DIV - 32'd1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next count: hold at zero while disabled, wrap at LAST.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (!enable_i) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q == LAST) begin
      cnt_d  = {CW{1'b0}};
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter and tick registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= {CW{1'b0}};
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/i2c_sensor_poller.sv
// Command sequencer in front of the I2C master: issues periodic or forced register
// reads of one sensor and publishes each good 16-bit result with a valid strobe.
module i2c_sensor_poller
  import i2c_pkg::*;
#(
  parameter int unsigned POLL_DIV = 5000000,
  parameter logic [6:0]  DEV_ADDR = DEFAULT_DEV_ADDR,
  parameter logic [7:0]  SUB_ADDR = DEFAULT_SUB_ADDR,
  parameter int unsigned RD_LEN   = 2,
  parameter int unsigned REQ_HOLD = 128,
  parameter int unsigned TIMEOUT  = 1000000
) (
  input  logic        clk_50,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        poll_now,
  output logic        i2c_request,
  output logic        i2c_wr,
  output logic [7:0]  i2c_length,
  output logic [6:0]  i2c_address,
  output logic [7:0]  i2c_sub_address,
  output logic [7:0]  i2c_tx,
  input  logic [7:0]  i2c_rx,
  input  logic        i2c_de,
  input  logic        i2c_busy,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        err,
  input  logic        err_clear,
  output logic [15:0] poll_count
);

  localparam logic [1:0]  LEN2      = 2'(RD_LEN);
  localparam logic [31:0] HOLD_LAST = 32'(REQ_HOLD - 32'd1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT - 32'd1);

  poll_state_e state_q;
  logic        pending_q;
  logic        request_q;
  logic        valid_q;
  logic        err_q;
  logic [1:0]  byte_cnt_q;
  logic [15:0] shift_q;
  logic [15:0] sample_q;
  logic [15:0] count_q;
  logic [31:0] wd_q;

  logic        tick_s;
  logic        new_req_s;
  logic        launch_s;
  logic        err_set_s;

  poll_timer #(
    .POLL_DIV (POLL_DIV)
  ) u_timer (
    .clk_i    (clk_50),
    .rst_ni   (reset_n),
    .enable_i (enable),
    .tick_o   (tick_s)
  );

  // Poll sources, launch decision and error-set conditions for this cycle.
  always_comb begin
    new_req_s = tick_s | poll_now;
    launch_s  = 1'b0;
    err_set_s = 1'b0;
    case (state_q)
      ST_IDLE: launch_s  = pending_q & ~i2c_busy;
      ST_DONE: err_set_s = (byte_cnt_q != LEN2);
      ST_ERR:  err_set_s = 1'b1;
      default: err_set_s = 1'b0;
    endcase
  end

  // Sequencer FSM with all datapath and output registers.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pending_q  <= 1'b0;
      request_q  <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      byte_cnt_q <= 2'd0;
      shift_q    <= 16'h0000;
      sample_q   <= 16'h0000;
      count_q    <= 16'h0000;
      wd_q       <= 32'd0;
    end else begin
      valid_q <= 1'b0;
      // A poll arriving on the launch cycle is kept for the next round.
      pending_q <= launch_s ? new_req_s : (pending_q | new_req_s);
      if (err_set_s) begin
        err_q <= 1'b1;
      end else if (err_clear) begin
        err_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (launch_s) begin
            state_q    <= ST_REQ;
            request_q  <= 1'b1;
            byte_cnt_q <= 2'd0;
            wd_q       <= 32'd0;
          end
        end
        ST_REQ: begin
          if (i2c_busy) begin
            state_q   <= ST_WAIT;
            request_q <= 1'b0;
            wd_q      <= 32'd0;
          end else if (wd_q == HOLD_LAST) begin
            state_q   <= ST_ERR;
            request_q <= 1'b0;
          end else begin
            wd_q <= wd_q + 32'd1;
          end
        end
        ST_WAIT: begin
          if (i2c_de) begin
            shift_q    <= {shift_q[7:0], i2c_rx};
            byte_cnt_q <= sat_inc2(byte_cnt_q);
          end
          if (!i2c_busy) begin
            state_q <= ST_DONE;
          end else if (wd_q == TO_LAST) begin
            state_q <= ST_ERR;
          end else begin
            wd_q <= wd_q + 32'd1;
          end
        end
        ST_DONE: begin
          if (byte_cnt_q == LEN2) begin
            sample_q <= (RD_LEN == 32'd2) ? shift_q : {shift_q[7:0], 8'h00};
            valid_q  <= 1'b1;
            count_q  <= count_q + 16'd1;
          end
          state_q <= ST_IDLE;
        end
        ST_ERR: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          request_q <= 1'b0;
        end
      endcase
    end
  end

  assign i2c_request     = request_q;
  assign i2c_wr          = I2C_READ;
  assign i2c_length      = 8'(RD_LEN);
  assign i2c_address     = DEV_ADDR;
  assign i2c_sub_address = SUB_ADDR;
  assign i2c_tx          = 8'h00;
  assign sample          = sample_q;
  assign sample_valid    = valid_q;
  assign err             = err_q;
  assign poll_count      = count_q;

endmodule

// File: tb/tb_i2c_sensor_poller.sv
// Bench for i2c_sensor_poller: emulated I2C master plus a transaction-level reference
// model compared against the DUT every cycle, with directed and random scenarios.
module tb_i2c_sensor_poller;

  localparam int POLL_DIV = 100;
  localparam int RD_LEN   = 2;
  localparam int REQ_HOLD = 16;
  localparam int TIMEOUT  = 200;

  logic        clk_50, reset_n, enable, poll_now, err_clear;
  logic        i2c_request, i2c_wr, i2c_de, i2c_busy, sample_valid, err;
  logic [7:0]  i2c_length, i2c_sub_address, i2c_tx, i2c_rx;
  logic [6:0]  i2c_address;
  logic [15:0] sample, poll_count;

  i2c_sensor_poller #(
    .POLL_DIV(POLL_DIV), .DEV_ADDR(7'b1001100), .SUB_ADDR(8'h01),
    .RD_LEN(RD_LEN), .REQ_HOLD(REQ_HOLD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_50(clk_50), .reset_n(reset_n), .enable(enable), .poll_now(poll_now),
    .i2c_request(i2c_request), .i2c_wr(i2c_wr), .i2c_length(i2c_length),
    .i2c_address(i2c_address), .i2c_sub_address(i2c_sub_address), .i2c_tx(i2c_tx),
    .i2c_rx(i2c_rx), .i2c_de(i2c_de), .i2c_busy(i2c_busy),
    .sample(sample), .sample_valid(sample_valid), .err(err), .err_clear(err_clear),
    .poll_count(poll_count)
  );

  initial begin
    clk_50 = 1'b0;
    forever #5 clk_50 = ~clk_50;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_50);
      #1;
    end
  endtask

  // Emulated master behaviour, sampled per transaction.
  int         cfg_ack = 3, cfg_nb = 2, cfg_gap = 1, cfg_hang = 0;
  logic       cfg_fall = 1'b0, cfg_noack = 1'b0;
  logic [7:0] cfg_d0 = 8'h1A, cfg_d1 = 8'h40, cfg_d2 = 8'h77;

  initial begin : responder
    int dly, nb, gap, hang;
    logic fall;
    logic [7:0] d0, d1, d2;
    i2c_busy = 1'b0; i2c_de = 1'b0; i2c_rx = 8'h00;
    forever begin
      cyc(1);
      if (reset_n && i2c_request && !cfg_noack) begin
        dly = cfg_ack; nb = cfg_nb; gap = cfg_gap; hang = cfg_hang; fall = cfg_fall;
        d0 = cfg_d0; d1 = cfg_d1; d2 = cfg_d2;
        cyc(dly);
        i2c_busy = 1'b1;
        cyc(1);
        if (hang > 0) begin
          cyc(hang);
        end else begin
          for (int i = 0; i < nb; i++) begin
            cyc(gap);
            i2c_de = 1'b1;
            i2c_rx = (i == 0) ? d0 : (i == 1) ? d1 : d2;
            if (fall && i == nb - 1) i2c_busy = 1'b0;
            cyc(1);
            i2c_de = 1'b0;
          end
        end
        i2c_busy = 1'b0;
      end
    end
  end

  // Reference model: transaction phases, collected bytes kept in a queue.
  typedef enum {M_IDLE, M_REQ, M_XFER, M_DONE, M_ERR} mphase_e;
  mphase_e     m_phase;
  int          m_timer, m_cyc;
  bit          m_tick, m_pending;
  logic [7:0]  m_bytes[$];
  logic        exp_req, exp_valid, exp_err;
  logic [15:0] exp_sample, exp_count;

  task automatic m_reset();
    m_phase = M_IDLE; m_timer = 0; m_cyc = 0; m_tick = 0; m_pending = 0;
    m_bytes.delete();
    exp_req = 0; exp_valid = 0; exp_err = 0; exp_sample = 16'h0000; exp_count = 16'h0000;
  endtask

  task automatic m_step();
    bit new_req, launch, set_err;
    new_req   = m_tick || poll_now;
    m_tick    = enable && (m_timer == POLL_DIV - 1);
    m_timer   = enable ? (m_timer + 1) % POLL_DIV : 0;
    launch    = (m_phase == M_IDLE) && m_pending && !i2c_busy;
    m_pending = launch ? new_req : (m_pending || new_req);
    set_err   = 0;
    exp_valid = 0;
    case (m_phase)
      M_IDLE: if (launch) begin
        m_phase = M_REQ; exp_req = 1; m_cyc = 0; m_bytes.delete();
      end
      M_REQ: if (i2c_busy) begin
        m_phase = M_XFER; exp_req = 0; m_cyc = 0;
      end else begin
        m_cyc++;
        if (m_cyc == REQ_HOLD) begin m_phase = M_ERR; exp_req = 0; end
      end
      M_XFER: begin
        if (i2c_de) m_bytes.push_back(i2c_rx);
        if (!i2c_busy) m_phase = M_DONE;
        else begin
          m_cyc++;
          if (m_cyc == TIMEOUT) m_phase = M_ERR;
        end
      end
      M_DONE: begin
        if (m_bytes.size() == RD_LEN) begin
          exp_sample = (RD_LEN == 2) ? {m_bytes[0], m_bytes[1]} : {m_bytes[0], 8'h00};
          exp_valid  = 1;
          exp_count  = exp_count + 16'd1;
        end else set_err = 1;
        m_phase = M_IDLE;
      end
      M_ERR: begin set_err = 1; m_phase = M_IDLE; end
      default: m_phase = M_IDLE;
    endcase
    if (set_err) exp_err = 1;
    else if (err_clear) exp_err = 0;
  endtask

  int   n_req_rise = 0, n_req_hi = 0, n_valid = 0, n_overlap = 0;
  logic req_prev = 1'b0;

  initial begin : scoreboard
    m_reset();
    forever begin
      @(negedge clk_50);
      if (!reset_n) m_reset();
      if (i2c_request && !req_prev) begin
        n_req_rise++;
        if (i2c_busy) n_overlap++;
      end
      if (i2c_request) n_req_hi++;
      if (sample_valid) n_valid++;
      req_prev = i2c_request;
      check("cycle", {29'd0, i2c_request, sample_valid, err, sample, poll_count},
            {29'd0, exp_req, exp_valid, exp_err, exp_sample, exp_count});
      if (reset_n) m_step();
    end
  end

  task automatic pulse_poll();
    poll_now = 1'b1; cyc(1); poll_now = 1'b0;
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1; cyc(1); err_clear = 1'b0;
  endtask

  initial begin : main
    int base_v, base_r, base_h, k;
    reset_n = 1'b0; enable = 1'b0; poll_now = 1'b0; err_clear = 1'b0;
    cyc(3);
    check("rst_request", i2c_request, 1'b0);
    check("rst_count", poll_count, 16'h0000);
    check("const_wr", i2c_wr, 1'b0);
    check("const_len", i2c_length, 8'd2);
    check("const_addr", i2c_address, 7'b1001100);
    check("const_sub", i2c_sub_address, 8'h01);
    check("const_tx", i2c_tx, 8'h00);
    reset_n = 1'b1;
    cyc(3);

    // Nominal read with latency check.
    base_v = n_valid;
    poll_now = 1'b1; cyc(1); poll_now = 1'b0;
    check("lat_n1", i2c_request, 1'b0);
    cyc(1);
    check("lat_n2", i2c_request, 1'b1);
    cyc(40);
    check("nom_sample", sample, 16'h1A40);
    check("nom_valid_cnt", n_valid - base_v, 1);
    check("nom_count", poll_count, 16'd1);
    check("nom_err", err, 1'b0);

    // Short read, then over-read with a byte on the busy fall.
    cfg_nb = 1; base_v = n_valid;
    pulse_poll(); cyc(40);
    check("short_err", err, 1'b1);
    check("short_valid", n_valid - base_v, 0);
    check("short_count", poll_count, 16'd1);
    pulse_clear(); cyc(1);
    check("clear_err", err, 1'b0);
    cfg_nb = 3; cfg_fall = 1'b1;
    pulse_poll(); cyc(40);
    check("over_err", err, 1'b1);
    check("over_sample", sample, 16'h1A40);
    pulse_clear(); cyc(2);
    cfg_nb = 2; cfg_fall = 1'b0;

    // No acknowledge.
    cfg_noack = 1'b1; base_h = n_req_hi;
    pulse_poll(); cyc(40);
    check("noack_req_cycles", n_req_hi - base_h, REQ_HOLD);
    check("noack_err", err, 1'b1);
    check("noack_sample", sample, 16'h1A40);
    cfg_noack = 1'b0;
    pulse_clear(); cyc(1);
    check("noack_clear", err, 1'b0);

    // Hung bus with a poll latched during the hang.
    cfg_hang = 300; cfg_d0 = 8'h55; cfg_d1 = 8'hAA; base_r = n_req_rise;
    pulse_poll(); cyc(20);
    cfg_hang = 0; cyc(30);
    pulse_poll(); cyc(200);
    check("hang_err", err, 1'b1);
    check("hang_req_low", i2c_request, 1'b0);
    cyc(150);
    check("hang_reqs", n_req_rise - base_r, 2);
    check("hang_sample", sample, 16'h55AA);
    check("hang_count", poll_count, 16'd2);
    pulse_clear(); cyc(49);

    // Periodic polling.
    cfg_ack = 2; cfg_gap = 0; base_r = n_req_rise;
    enable = 1'b1; cyc(1050); enable = 1'b0;
    cyc(30);
    check("periodic_reqs", n_req_rise - base_r, 10);
    check("periodic_count", poll_count, 16'd12);
    check("periodic_overlap", n_overlap, 0);

    // Reset in the middle of a transfer.
    cfg_ack = 3; cfg_gap = 2; cfg_d0 = 8'hC3; cfg_d1 = 8'h3C;
    pulse_poll();
    k = 0;
    while (!i2c_busy && k < 30) begin cyc(1); k++; end
    check("reset_busy_seen", i2c_busy, 1'b1);
    cyc(2);
    reset_n = 1'b0; #1;
    check("rst_mid_req", i2c_request, 1'b0);
    check("rst_mid_sample", sample, 16'h0000);
    check("rst_mid_count", poll_count, 16'h0000);
    cyc(2); reset_n = 1'b1; cyc(1);
    pulse_poll(); cyc(80);
    check("post_rst_count", poll_count, 16'd1);
    check("post_rst_sample", sample, 16'hC33C);
    check("post_rst_err", err, 1'b0);

    // Randomized traffic checked by the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      poll_now  = ($urandom_range(0, 39) == 0);
      err_clear = ($urandom_range(0, 29) == 0);
      cfg_ack   = $urandom_range(1, 5);
      k         = $urandom_range(0, 9);
      cfg_nb    = (k == 0) ? 1 : (k == 1) ? 3 : 2;
      cfg_gap   = $urandom_range(0, 3);
      cfg_fall  = $urandom_range(0, 1);
      cfg_noack = ($urandom_range(0, 19) == 0);
      cfg_d0    = 8'($urandom); cfg_d1 = 8'($urandom); cfg_d2 = 8'($urandom);
      cyc(1);
    end
    enable = 1'b0; poll_now = 1'b0; err_clear = 1'b0; cfg_noack = 1'b0;
    cyc(300);
    check("final_overlap", n_overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_sensor_poller.md
Name: i2c_sensor_poller

Overview:
Upstream command sequencer for the I2C master.
- Periodically, or on demand, issues a register read to a fixed sensor (default device 7'b1001100, sub-address 8'h01).
- Collects the returned bytes and presents one 16-bit sample with a valid strobe.
- Sole driver of the master's WR/length/request/address/sub_address/txReg inputs; sole consumer of its rxReg/DE/busy outputs.

Parameters:
POLL_DIV, 5000000, clk_50 cycles between automatic polls (100 ms at 50 MHz); minimum 2
DEV_ADDR, 7'b1001100, 7-bit device address
SUB_ADDR, 8'h01, register sub-address
RD_LEN, 2, bytes per read; legal 1 or 2
REQ_HOLD, 128, max cycles request stays high waiting for busy
TIMEOUT, 1000000, max cycles from busy rise to busy fall

Ports:
clk_50  in  1  50 MHz master clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  level; permits automatic polls
poll_now  in  1  single-cycle pulse; force a poll
i2c_request  out  1  to master request
i2c_wr  out  1  to master WR; constant 0 (read)
i2c_length  out  8  to master length; constant RD_LEN
i2c_address  out  7  constant DEV_ADDR
i2c_sub_address  out  8  constant SUB_ADDR
i2c_tx  out  8  to master txReg; constant 8'h00
i2c_rx  in  8  from master rxReg
i2c_de  in  1  from master DE; 1-cycle pulse per completed byte, i2c_rx valid that cycle
i2c_busy  in  1  from master busy
sample  out  16  last good sample, first byte in [15:8]
sample_valid  out  1  1-cycle pulse when sample updates
err  out  1  sticky error flag
err_clear  in  1  pulse; clears err
poll_count  out  16  count of successful polls; wraps at 16'hFFFF -> 0

Behaviour:
- Reset (async assert, sync release): all of the following go to 0:
  - outputs: i2c_request, sample, sample_valid, err, poll_count;
  - internal state: timer, pending flag, byte count.
  - Constant outputs hold their constant value in reset.
  - State goes to IDLE.
- Timer: counts 0..POLL_DIV-1 while enable=1 and wraps. Wrap produces tick. Timer holds at 0 while enable=0.
- Pending flag: set by tick or poll_now. Cleared on IDLE->REQ. Requests arriving while not in IDLE set it once; one-deep, extras are dropped.
- IDLE: pending=1 and i2c_busy=0 -> REQ next cycle.
- REQ:
  - i2c_request=1; byte count cleared.
  - i2c_busy=1 -> WAIT: request drops the same cycle busy is sampled high.
  - REQ_HOLD cycles with no busy -> ERR.
- WAIT:
  - Each i2c_de pulse shifts i2c_rx into a 16-bit shift register and increments the byte count (saturating at 3).
  - i2c_busy falls -> DONE. A de pulse in the same cycle as the busy fall is counted.
  - TIMEOUT cycles elapse -> ERR.
- DONE (1 cycle):
  - byte count == RD_LEN:
    - RD_LEN=2: sample = shift register.
    - RD_LEN=1: sample = {byte, 8'h00}.
    - sample_valid=1; poll_count+1.
  - Otherwise (short or over-read): err=1, sample unchanged.
  - -> IDLE.
- ERR (1 cycle): err=1; i2c_request=0; -> IDLE.
- No new request is issued until i2c_busy=0 in IDLE, so the master never sees request while busy.
- err_clear in the same cycle as a new error: the set wins.
- enable falling mid-transaction: the current transaction completes normally; the timer stops. The pending flag is kept, so a latched poll still runs.
- Latency: poll_now at cycle N -> i2c_request high at N+2 (IDLE idle case).
- Reset mid-transaction: request drops immediately; master-side recovery is the master's responsibility.

Decomposition:
- Shared package i2c_pkg:
  - state enum (IDLE, REQ, WAIT, DONE, ERR);
  - I2C_WRITE/I2C_READ WR encodings;
  - default device and sub-address constants shared with the master bench.
- One sub-module poll_timer (POLL_DIV counter, enable, tick output).

Test Plan:
- Nominal read: poll_now pulse; model asserts busy 3 cycles after request, returns de with 8'h1A then 8'h40, drops busy -> sample=16'h1A40, one sample_valid pulse, poll_count=1, err=0.
- Periodic: POLL_DIV=100, enable=1, 1000 cycles, each transaction 20 cycles -> exactly 10 requests, requests never overlap busy.
- No acknowledge: model never raises busy -> request high exactly REQ_HOLD cycles, then err=1, sample unchanged; err_clear -> err=0.
- Short read: RD_LEN=2, only one de before busy falls -> err=1, no sample_valid, poll_count unchanged.
- Hung bus: busy stays high -> ERR after TIMEOUT cycles; a poll_now during the hang is executed once, right after busy drops.
- Reset mid-WAIT: reset_n low for 2 cycles -> request=0, sample=0, poll_count=0 immediately; after release a poll_now completes normally.
